lighthouse_pulse_decoder: RTL
=============================

Name: lighthouse_pulse_decoder

Overview:
Upstream front-end for one lighthouse photodiode input. It does the following:
- Synchronises and deglitches the raw sensor line.
- Timestamps pulse edges against the shared free-running timer.
- Classifies each pulse as sync or sweep and decodes the sync code.
- Emits one sweep record per rotation: angle ticks relative to the sync, plus axis.
Records leave over a valid/ready handshake to the Avalon register bridge, which reads them out to software.

Parameters:
TIMER_W, 32, width of timer input and all timestamps
GLITCH_CYCLES, 4, cycles a synchronised level must be stable before the filtered level changes
SYNC_BASE, 3125, sync-pulse width in cycles for code 0 (62.5 us @ 50 MHz)
SYNC_STEP, 521, sync width increment per code step (10.42 us)
SWEEP_MAX, 1000, maximum width in cycles classified as sweep
SYNC_TIMEOUT, 1000000, cycles after last sync rise before lock is dropped

Ports:
clock  in  1  system clock
reset  in  1  asynchronous, active-high
sensor_i  in  1  raw photodiode signal, asynchronous
timer  in  TIMER_W  shared free-running counter, wraps modulo 2^TIMER_W
out_valid  out  1  sweep record available
out_ready  in  1  consumer accepts record
out_ticks  out  TIMER_W  sweep centre minus sync rise time
out_axis  out  1  axis bit of the governing sync
out_data  out  1  data bit of the governing sync
locked  out  1  a valid non-skip or skip sync seen within SYNC_TIMEOUT
sync_code  out  3  last decoded sync code

Behaviour:
- Reset: all outputs 0, FSM IDLE, filter cleared to low, edge state LOW.
- Input conditioning:
  - 2-flop synchroniser, then stability counter.
  - Filtered level changes only after GLITCH_CYCLES consecutive equal synchronised samples.
  - A raw change therefore appears 2+GLITCH_CYCLES cycles later.
- Edge capture:
  - Filtered rise latches rise_t = timer.
  - Filtered fall computes width = timer - rise_t (unsigned, modulo 2^TIMER_W).
  - A fall with no prior rise since reset is ignored.
- Classification on fall, registered one cycle later:
  - Sync: width in [SYNC_BASE-SYNC_STEP/2, SYNC_BASE+7*SYNC_STEP+SYNC_STEP/2). code = number of boundaries SYNC_BASE+k*SYNC_STEP-SYNC_STEP/2 (k=1..7) that width is at or above. Compare ladder only, no divider.
  - code bits: [0] axis, [1] data, [2] skip.
  - Sweep: width <= SWEEP_MAX.
  - Anything else: rejected, no state change.
- Sweep-window FSM:
  - IDLE: sync with skip=0 → ARMED (latch sync_t=its rise_t, axis, data). Sync with skip=1 → WAIT_OTHER.
  - ARMED: first sweep → emit record, → WAIT_SYNC. Any sync → re-evaluate as in IDLE.
  - WAIT_SYNC / WAIT_OTHER: sweeps ignored (counted as rejects). Syncs handled as in IDLE.
  - Any state except IDLE: timer - last sync rise > SYNC_TIMEOUT → IDLE, locked=0.
  - locked=1 whenever the FSM is not IDLE.
- Record:
  - centre = rise_t + (width>>1).
  - out_ticks = centre - sync_t, modulo 2^TIMER_W, so timer wrap is transparent.
  - out_valid rises 2 cycles after the filtered fall.
- Handshake:
  - Single output register.
  - Record is held stable while out_valid && !out_ready.
  - Cleared on out_valid && out_ready.
  - A new record arriving while the register is occupied is dropped. The older record is kept.
  - If the new record arrives in the same cycle as acceptance, the new record loads.
- Reset mid-pulse: everything returns to reset values. The pulse in progress is not reported, because its rise was lost.

Optional Feature:
PULSE_DECODER_STATS_EN.
- Defined:
  - adds outputs drop_count[15:0] and reject_count[15:0], reset to 0, both saturating at 16'hFFFF.
  - drop_count increments on each dropped record.
  - reject_count increments on each rejected width and each ignored sweep.
- Undefined: ports and counters absent; all other behaviour identical.

Decomposition:
- Shared package lighthouse_pkg:
  - sync-code bit indices (AXIS=0, DATA=1, SKIP=2)
  - FSM state enum (IDLE, ARMED, WAIT_SYNC, WAIT_OTHER)
  - default 50 MHz timing constants
- Sub-module lighthouse_deglitch: synchroniser plus stability filter, parameter GLITCH_CYCLES. It is natural and reusable for the other 15 sensor channels.

Test Plan:
- Sync rise at timer=1000, width 3125; sweep rise at timer=101000, width 200 → out_ticks=100100, out_axis=0, out_data=0, sync_code=0, locked=1.
- Sync width 3646 (code 1), then sweep → out_axis=1. Sync width 5209 (code 4, skip), then sweep → no out_valid; stats build: reject_count=1.
- Wrap:
  - Stimulus: sync rise at 0xFFFFFF00; sweep rise at 0x00000100, width 100.
  - Required response: out_ticks=0x232.
- Glitches:
  - 3-cycle high blip with GLITCH_CYCLES=4 → no edge, no record.
  - Pulse width 1500 → rejected, FSM state unchanged.
- Backpressure:
  - Stimulus: out_ready=0; two sync+sweep rotations.
  - Required response: the first record is held unchanged. Stats build: drop_count=1.
  - Then assert out_ready → record accepted, out_valid falls the next cycle.
- Timeout and reset:
  - No sync for 1000001 cycles after lock → locked=0, sweeps ignored.
  - Reset asserted mid-pulse → all outputs 0. The next full sync/sweep decodes correctly.

Source files
------------

// File: rtl/lighthouse_pkg.sv
// Shared definitions for the lighthouse photodiode front-end: sync-code bit
// positions, sweep-window and pulse-class encodings, default 50 MHz timing.
package lighthouse_pkg;

  localparam int CODE_AXIS = 0;
  localparam int CODE_DATA = 1;
  localparam int CODE_SKIP = 2;

  localparam int DEF_TIMER_W       = 32;
  localparam int DEF_GLITCH_CYCLES = 4;
  localparam int DEF_SYNC_BASE     = 3125;
  localparam int DEF_SYNC_STEP     = 521;
  localparam int DEF_SWEEP_MAX     = 1000;
  localparam int DEF_SYNC_TIMEOUT  = 1000000;

  typedef enum logic [1:0] {
    IDLE,
    ARMED,
    WAIT_SYNC,
    WAIT_OTHER
  } sweep_state_e;

  typedef enum logic [1:0] {
    PULSE_REJECT,
    PULSE_SYNC,
    PULSE_SWEEP
  } pulse_class_e;

endpackage

// File: rtl/lighthouse_deglitch.sv
// Two-flop synchroniser followed by a stability filter: the filtered level only
// follows the synchronised input after GLITCH_CYCLES consecutive equal samples.
module lighthouse_deglitch #(
  parameter int GLITCH_CYCLES = 4
) (
  input  logic clock,
  input  logic reset,
  input  logic sensor_i,
  output logic sync_level,
  output logic level
);

  localparam int CNT_W = $clog2(GLITCH_CYCLES + 1);

  logic [1:0]       sync_reg;
  logic [CNT_W-1:0] stable_count_reg;
  logic             level_reg;

  // Synchroniser resets high so a line that is already high at reset release
  // never looks like a fresh low-to-high transition downstream.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      sync_reg         <= 2'b11;
      stable_count_reg <= '0;
      level_reg        <= 1'b0;
    end else begin
      sync_reg <= {sync_reg[0], sensor_i};
      if (sync_reg[1] == level_reg) begin
        stable_count_reg <= '0;
      end else if (stable_count_reg == CNT_W'(GLITCH_CYCLES - 1)) begin
        level_reg        <= sync_reg[1];
        stable_count_reg <= '0;
      end else begin
        stable_count_reg <= stable_count_reg + 1'b1;
      end
    end
  end

  assign sync_level = sync_reg[1];
  assign level      = level_reg;

endmodule

// File: rtl/lighthouse_pulse_decoder.sv
// One photodiode channel: deglitch, edge timestamping, sync/sweep classification
// and one sweep record per rotation. Define PULSE_DECODER_STATS_EN for counters.
module lighthouse_pulse_decoder
  import lighthouse_pkg::*;
#(
  parameter int TIMER_W       = DEF_TIMER_W,
  parameter int GLITCH_CYCLES = DEF_GLITCH_CYCLES,
  parameter int SYNC_BASE     = DEF_SYNC_BASE,
  parameter int SYNC_STEP     = DEF_SYNC_STEP,
  parameter int SWEEP_MAX     = DEF_SWEEP_MAX,
  parameter int SYNC_TIMEOUT  = DEF_SYNC_TIMEOUT
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               sensor_i,
  input  logic [TIMER_W-1:0] timer,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [TIMER_W-1:0] out_ticks,
  output logic               out_axis,
  output logic               out_data,
  output logic               locked,
  output logic [2:0]         sync_code
`ifdef PULSE_DECODER_STATS_EN
  ,
  output logic [15:0]        drop_count,
  output logic [15:0]        reject_count
`endif
);

  localparam logic [TIMER_W-1:0] SYNC_LO   = TIMER_W'(SYNC_BASE - SYNC_STEP / 2);
  localparam logic [TIMER_W-1:0] SYNC_HI   = TIMER_W'(SYNC_BASE + 7 * SYNC_STEP + SYNC_STEP / 2);
  localparam logic [TIMER_W-1:0] SWEEP_LIM = TIMER_W'(SWEEP_MAX);
  localparam logic [TIMER_W-1:0] TIMEOUT_T = TIMER_W'(SYNC_TIMEOUT);

  logic sync_level, level;
  logic level_d_reg, seen_low_reg, have_rise_reg;
  logic rise_evt, fall_evt;
  logic [TIMER_W-1:0] rise_t_reg, width_now;
  logic [6:0] above;
  logic [2:0] code_now;
  pulse_class_e class_now;

  logic               pulse_valid_reg;
  pulse_class_e       pulse_class_reg;
  logic [2:0]         pulse_code_reg;
  logic [TIMER_W-1:0] pulse_rise_reg, pulse_width_reg;

  sweep_state_e state_reg, state_next, cur_state;
  logic timed_out, take_sync, emit;
  logic [TIMER_W-1:0] sync_t_reg, record_ticks;
  logic [2:0] sync_code_reg;
  logic out_valid_reg, out_axis_reg, out_data_reg;
  logic [TIMER_W-1:0] out_ticks_reg;

  lighthouse_deglitch #(.GLITCH_CYCLES(GLITCH_CYCLES)) u_deglitch (
    .clock      (clock),
    .reset      (reset),
    .sensor_i   (sensor_i),
    .sync_level (sync_level),
    .level      (level)
  );

  assign rise_evt  = level & ~level_d_reg;
  assign fall_evt  = ~level & level_d_reg;
  assign width_now = timer - rise_t_reg;

  // Code ladder: one comparator per boundary between adjacent sync codes.
  for (genvar gi = 0; gi < 7; gi++) begin : g_ladder
    assign above[gi] = width_now >= TIMER_W'(SYNC_BASE + (gi + 1) * SYNC_STEP - SYNC_STEP / 2);
  end

  always_comb begin
    code_now = 3'd0;
    for (int i = 0; i < 7; i++) code_now = code_now + 3'(above[i]);
    if (width_now >= SYNC_LO && width_now < SYNC_HI) class_now = PULSE_SYNC;
    else if (width_now <= SWEEP_LIM)                class_now = PULSE_SWEEP;
    else                                            class_now = PULSE_REJECT;
  end

  // A rise only counts once the line has been seen low since reset, so a pulse
  // already in progress at reset release is never measured.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      level_d_reg     <= 1'b0;
      seen_low_reg    <= 1'b0;
      have_rise_reg   <= 1'b0;
      rise_t_reg      <= '0;
      pulse_valid_reg <= 1'b0;
      pulse_class_reg <= PULSE_REJECT;
      pulse_code_reg  <= 3'd0;
      pulse_rise_reg  <= '0;
      pulse_width_reg <= '0;
    end else begin
      level_d_reg <= level;
      if (!sync_level) seen_low_reg <= 1'b1;
      if (rise_evt && seen_low_reg) begin
        rise_t_reg    <= timer;
        have_rise_reg <= 1'b1;
      end else if (fall_evt) begin
        have_rise_reg <= 1'b0;
      end
      pulse_valid_reg <= fall_evt && have_rise_reg;
      pulse_class_reg <= class_now;
      pulse_code_reg  <= code_now;
      pulse_rise_reg  <= rise_t_reg;
      pulse_width_reg <= width_now;
    end
  end

  always_comb begin
    timed_out  = (state_reg != IDLE) && ((timer - sync_t_reg) > TIMEOUT_T);
    cur_state  = timed_out ? IDLE : state_reg;
    state_next = cur_state;
    take_sync  = 1'b0;
    emit       = 1'b0;
    if (pulse_valid_reg) begin
      case (pulse_class_reg)
        PULSE_SYNC: begin
          take_sync  = 1'b1;
          state_next = pulse_code_reg[CODE_SKIP] ? WAIT_OTHER : ARMED;
        end
        PULSE_SWEEP: begin
          if (cur_state == ARMED) begin
            emit       = 1'b1;
            state_next = WAIT_SYNC;
          end
        end
        default: ;
      endcase
    end
  end

  assign record_ticks = pulse_rise_reg + (pulse_width_reg >> 1) - sync_t_reg;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_reg     <= IDLE;
      sync_t_reg    <= '0;
      sync_code_reg <= 3'd0;
      out_valid_reg <= 1'b0;
      out_ticks_reg <= '0;
      out_axis_reg  <= 1'b0;
      out_data_reg  <= 1'b0;
    end else begin
      state_reg <= state_next;
      if (take_sync) begin
        sync_t_reg    <= pulse_rise_reg;
        sync_code_reg <= pulse_code_reg;
      end
      // A full register keeps its record; a new one only loads into a free slot.
      if (emit && (!out_valid_reg || out_ready)) begin
        out_valid_reg <= 1'b1;
        out_ticks_reg <= record_ticks;
        out_axis_reg  <= sync_code_reg[CODE_AXIS];
        out_data_reg  <= sync_code_reg[CODE_DATA];
      end else if (out_valid_reg && out_ready) begin
        out_valid_reg <= 1'b0;
      end
    end
  end

  assign out_valid = out_valid_reg;
  assign out_ticks = out_ticks_reg;
  assign out_axis  = out_axis_reg;
  assign out_data  = out_data_reg;
  assign locked    = (state_reg != IDLE);
  assign sync_code = sync_code_reg;

`ifdef PULSE_DECODER_STATS_EN
  logic drop_evt, reject_evt;
  logic [15:0] drop_count_reg, reject_count_reg;

  assign drop_evt   = emit && out_valid_reg && !out_ready;
  assign reject_evt = pulse_valid_reg &&
                      (pulse_class_reg == PULSE_REJECT || (pulse_class_reg == PULSE_SWEEP && !emit));

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      drop_count_reg   <= 16'd0;
      reject_count_reg <= 16'd0;
    end else begin
      if (drop_evt && drop_count_reg != 16'hFFFF)     drop_count_reg   <= drop_count_reg + 16'd1;
      if (reject_evt && reject_count_reg != 16'hFFFF) reject_count_reg <= reject_count_reg + 16'd1;
    end
  end

  assign drop_count   = drop_count_reg;
  assign reject_count = reject_count_reg;
`endif

endmodule
